// File: rtl/exec_ev_port.sv
// Execution-environment access port: local word/dword storage plus optional shared words.
// Define EXEC_EV_SHARED_EN to build the shared word region.
module exec_ev_port #(
  parameter int unsigned NUM_WORDS  = 16,
  parameter int unsigned NUM_SHARED = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic        req_size,
  input  logic        req_shared,
  input  logic [7:0]  req_index,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned SW = (NUM_SHARED > 1) ? $clog2(NUM_SHARED) : 1;
`ifdef EXEC_EV_SHARED_EN
  localparam int unsigned CLR_CYCLES = NUM_WORDS + NUM_SHARED;
`else
  localparam int unsigned CLR_CYCLES = NUM_WORDS;
`endif
  localparam int unsigned CW = $clog2(CLR_CYCLES + 1);
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_CLEAR = 2'd2;
  localparam logic [1:0] OP_RSVD  = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_ACCESS, S_HIGH, S_CLEAR, S_RESP} state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [31:0]     r_words [NUM_WORDS];
  logic [1:0]      r_op;
  logic            r_size;
  logic            r_shared;
  logic [7:0]      r_index;
  logic [63:0]     r_wdata;
  logic [CW-1:0]   r_clr_cnt;

  logic            r_req_ready;
  logic            r_rsp_valid;
  logic            r_rsp_err;
  logic [63:0]     r_rsp_rdata;

  logic            w_accept;
  logic            w_req_err;
  logic            w_req_ready_nxt;
  logic            w_rsp_valid_nxt;
  logic            w_rsp_err_nxt;
  logic [63:0]     w_rsp_rdata_nxt;
  logic            w_loc_we;
  logic [AW-1:0]   w_loc_idx;
  logic [31:0]     w_loc_wdata;
  logic            w_sh_we;
  logic [SW-1:0]   w_sh_idx;
  logic [31:0]     w_sh_wdata;
  logic [31:0]     w_sh_rword;
  logic [AW-1:0]   w_lo_idx;
  logic [AW-1:0]   w_hi_idx;

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  assign w_accept = req_valid && r_req_ready;
  assign w_lo_idx = r_size ? AW'({r_index, 1'b0}) : AW'(r_index);
  assign w_hi_idx = {w_lo_idx[AW-1:1], 1'b1};

  // Request validation; a clear ignores size and index.
  always_comb begin
    w_req_err = 1'b0;
    if (req_op == OP_RSVD) begin
      w_req_err = 1'b1;
    end else if (req_shared) begin
`ifdef EXEC_EV_SHARED_EN
      w_req_err = (req_op != OP_CLEAR) && (req_size || (32'(req_index) >= NUM_SHARED));
`else
      w_req_err = 1'b1;
`endif
    end else if (req_op != OP_CLEAR) begin
      if (req_size) w_req_err = 32'(req_index) >= (NUM_WORDS / 2);
      else          w_req_err = 32'(req_index) >= NUM_WORDS;
    end
  end

`ifdef EXEC_EV_SHARED_EN
  logic [31:0] r_shared_mem [NUM_SHARED];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_SHARED; i++) r_shared_mem[i] <= '0;
    end else if (w_sh_we) begin
      r_shared_mem[w_sh_idx] <= w_sh_wdata;
    end
  end

  assign w_sh_rword = r_shared_mem[SW'(r_index)];
`else
  logic w_unused_sh;
  assign w_unused_sh = ^{w_sh_we, w_sh_idx, w_sh_wdata};
  assign w_sh_rword  = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state, response updates and storage write port.
  always_comb begin
    w_state_nxt     = r_state;
    w_req_ready_nxt = 1'b0;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_err_nxt   = r_rsp_err;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_loc_we        = 1'b0;
    w_loc_idx       = w_lo_idx;
    w_loc_wdata     = r_wdata[31:0];
    w_sh_we         = 1'b0;
    w_sh_idx        = SW'(r_index);
    w_sh_wdata      = r_wdata[31:0];
    unique case (r_state)
      S_IDLE: begin
        w_req_ready_nxt = 1'b1;
        if (w_accept) begin
          w_req_ready_nxt = 1'b0;
          w_rsp_rdata_nxt = '0;
          w_rsp_err_nxt   = 1'b0;
          if (w_req_err) begin
            w_state_nxt     = S_RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
          end else if (req_op == OP_CLEAR) begin
            w_state_nxt = S_CLEAR;
          end else begin
            w_state_nxt = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (r_shared) begin
          if (r_op == OP_WRITE) w_sh_we = 1'b1;
          else                  w_rsp_rdata_nxt = {32'd0, w_sh_rword};
        end else begin
          if (r_op == OP_WRITE) w_loc_we = 1'b1;
          else                  w_rsp_rdata_nxt = {32'd0, r_words[w_lo_idx]};
        end
        if (r_size) begin
          w_state_nxt = S_HIGH;
        end else begin
          w_state_nxt     = S_RESP;
          w_rsp_valid_nxt = 1'b1;
        end
      end
      S_HIGH: begin
        w_loc_idx   = w_hi_idx;
        w_loc_wdata = r_wdata[63:32];
        if (r_op == OP_WRITE) w_loc_we = 1'b1;
        else                  w_rsp_rdata_nxt[63:32] = r_words[w_hi_idx];
        w_state_nxt     = S_RESP;
        w_rsp_valid_nxt = 1'b1;
      end
      S_CLEAR: begin
        w_loc_wdata = '0;
        w_sh_wdata  = '0;
        if (32'(r_clr_cnt) < NUM_WORDS) begin
          w_loc_we  = 1'b1;
          w_loc_idx = AW'(r_clr_cnt);
        end else begin
          w_sh_we  = 1'b1;
          w_sh_idx = SW'(32'(r_clr_cnt) - NUM_WORDS);
        end
        if (32'(r_clr_cnt) == CLR_CYCLES - 1) begin
          w_state_nxt     = S_RESP;
          w_rsp_valid_nxt = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt     = S_IDLE;
          w_req_ready_nxt = 1'b1;
          w_rsp_valid_nxt = 1'b0;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_rdata_nxt = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs and request capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      r_op        <= '0;
      r_size      <= 1'b0;
      r_shared    <= 1'b0;
      r_index     <= '0;
      r_wdata     <= '0;
      r_clr_cnt   <= '0;
    end else begin
      r_req_ready <= w_req_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      if (w_accept) begin
        r_op      <= req_op;
        r_size    <= req_size;
        r_shared  <= req_shared;
        r_index   <= req_index;
        r_wdata   <= req_wdata;
        r_clr_cnt <= '0;
      end else if (r_state == S_CLEAR) begin
        r_clr_cnt <= r_clr_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_WORDS; i++) r_words[i] <= '0;
    end else if (w_loc_we) begin
      r_words[w_loc_idx] <= w_loc_wdata;
    end
  end

endmodule

// File: tb/tb_exec_ev_port.sv
// Bench for exec_ev_port: directed vector table, random traffic against an array model,
// backpressure and mid-dword reset sequences.
module tb_exec_ev_port;

  localparam int NW = 16;
  localparam int NS = 4;
`ifdef EXEC_EV_SHARED_EN
  localparam bit SHARED_EN = 1'b1;
  localparam int CLR_LAT   = NW + NS;
`else
  localparam bit SHARED_EN = 1'b0;
  localparam int CLR_LAT   = NW;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic        req_size, req_shared;
  logic [7:0]  req_index;
  logic [63:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  exec_ev_port #(.NUM_WORDS(NW), .NUM_SHARED(NS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_size(req_size), .req_shared(req_shared), .req_index(req_index),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] m_loc [NW];
  logic [31:0] m_sh  [NS];

  typedef struct {
    logic [1:0]  op;
    logic        size;
    logic        sh;
    logic [7:0]  idx;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic [1:0] op, input logic size, input logic sh,
                              input int idx, input logic [63:0] wd,
                              input logic [63:0] er, input logic ee);
    vec_t v;
    v.op = op; v.size = size; v.sh = sh; v.idx = 8'(idx); v.wdata = wd;
    v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  function automatic int lat_of(input logic [1:0] op, input logic size, input logic err);
    if (err) return 0;
    if (op == 2'd2) return CLR_LAT;
    return size ? 2 : 1;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Reference model: plain array semantics of one request.
  task automatic model(input logic [1:0] op, input logic size, input logic sh, input logic [7:0] idx,
                       input logic [63:0] wd, output logic [63:0] r, output logic e);
    int i;
    i = int'(idx);
    r = '0;
    e = 1'b0;
    if (op == 2'd3) e = 1'b1;
    else if (sh && !SHARED_EN) e = 1'b1;
    else if (op == 2'd2) begin
      for (int k = 0; k < NW; k++) m_loc[k] = '0;
      for (int k = 0; k < NS; k++) m_sh[k] = '0;
    end else if (sh) begin
      if (size || i >= NS) e = 1'b1;
      else if (op == 2'd1) m_sh[i] = wd[31:0];
      else r = {32'd0, m_sh[i]};
    end else if (size) begin
      if (i >= NW / 2) e = 1'b1;
      else if (op == 2'd1) begin m_loc[2*i] = wd[31:0]; m_loc[2*i+1] = wd[63:32]; end
      else r = {m_loc[2*i+1], m_loc[2*i]};
    end else begin
      if (i >= NW) e = 1'b1;
      else if (op == 2'd1) m_loc[i] = wd[31:0];
      else r = {32'd0, m_loc[i]};
    end
  endtask

  // Issue one request (called at a negedge), check latency/data/err, hold then take the response.
  task automatic run_req(input string name, input logic [1:0] op, input logic size, input logic sh,
                         input logic [7:0] idx, input logic [63:0] wd,
                         input logic [63:0] exp_r, input logic exp_e, input int hold);
    int n;
    int lat;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin
      check({name, "_ready_timeout"}, 64'(req_ready), 64'd1);
      return;
    end
    req_valid = 1'b1; req_op = op; req_size = size; req_shared = sh;
    req_index = idx; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    check({name, "_lat"}, 64'(lat), 64'(lat_of(op, size, exp_e)));
    if (!rsp_valid) return;
    check({name, "_rdata"}, rsp_rdata, exp_r);
    check({name, "_err"}, 64'(rsp_err), 64'(exp_e));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({name, "_hold"}, {rsp_valid, req_ready, rsp_err, rsp_rdata[60:0]},
            {1'b1, 1'b0, exp_e, exp_r[60:0]});
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({name, "_taken"}, {62'd0, rsp_valid, req_ready}, 64'b01);
    @(negedge clk);
  endtask

  task automatic run_model(input string name, input logic [1:0] op, input logic size, input logic sh,
                           input logic [7:0] idx, input logic [63:0] wd, input int hold);
    logic [63:0] r;
    logic e;
    model(op, size, sh, idx, wd, r, e);
    run_req(name, op, size, sh, idx, wd, r, e, hold);
  endtask

  initial begin
    logic [1:0] op;
    logic sz, sh;
    logic [7:0] idx;
    int pick;

    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_size = 1'b0; req_shared = 1'b0;
    req_index = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {60'd0, req_ready, rsp_valid, rsp_err, |rsp_rdata}, 64'b1000);
    rst_n = 1'b1;
    @(negedge clk);

    vt.push_back(mk(2'd1, 0, 0, 0, 64'd10, 64'd0, 0));
    vt.push_back(mk(2'd1, 0, 0, 1, 64'd14, 64'd0, 0));
    vt.push_back(mk(2'd0, 1, 0, 0, 64'd0, 64'h0000000E_0000000A, 0));
    vt.push_back(mk(2'd1, 1, 0, 0, 64'd1780, 64'd0, 0));
    vt.push_back(mk(2'd0, 0, 0, 0, 64'd0, 64'd1780, 0));
    vt.push_back(mk(2'd0, 0, 0, 1, 64'd0, 64'd0, 0));
    vt.push_back(mk(2'd1, 0, 1, 0, 64'd65, 64'd0, !SHARED_EN));
    vt.push_back(mk(2'd0, 0, 1, 0, 64'd0, SHARED_EN ? 64'd65 : 64'd0, !SHARED_EN));
    vt.push_back(mk(2'd0, 0, 0, 0, 64'd0, 64'd1780, 0));
    vt.push_back(mk(2'd1, 0, 0, 16, 64'd5, 64'd0, 1));
    vt.push_back(mk(2'd0, 0, 0, 0, 64'd0, 64'd1780, 0));
    vt.push_back(mk(2'd1, 1, 0, 8, 64'h00000077_00000077, 64'd0, 1));
    vt.push_back(mk(2'd0, 1, 0, 0, 64'd0, 64'd1780, 0));
    vt.push_back(mk(2'd3, 0, 0, 0, 64'd9, 64'd0, 1));
    vt.push_back(mk(2'd0, 0, 0, 0, 64'd0, 64'd1780, 0));
    vt.push_back(mk(2'd0, 0, 1, 4, 64'd0, 64'd0, 1));
    vt.push_back(mk(2'd0, 1, 1, 0, 64'd0, 64'd0, 1));
    vt.push_back(mk(2'd1, 0, 0, 15, 64'hDEAD, 64'd0, 0));
    vt.push_back(mk(2'd1, 0, 1, 3, 64'h77, 64'd0, !SHARED_EN));
    vt.push_back(mk(2'd2, 0, 0, 0, 64'd0, 64'd0, 0));
    vt.push_back(mk(2'd0, 0, 0, 0, 64'd0, 64'd0, 0));
    vt.push_back(mk(2'd0, 0, 0, 15, 64'd0, 64'd0, 0));
    vt.push_back(mk(2'd0, 1, 0, 0, 64'd0, 64'd0, 0));
    vt.push_back(mk(2'd0, 0, 1, 0, 64'd0, 64'd0, !SHARED_EN));
    vt.push_back(mk(2'd0, 0, 1, 3, 64'd0, 64'd0, !SHARED_EN));
    vt.push_back(mk(2'd2, 0, 1, 0, 64'd0, 64'd0, !SHARED_EN));

    foreach (vt[k])
      run_req($sformatf("vec%0d", k), vt[k].op, vt[k].size, vt[k].sh, vt[k].idx,
              vt[k].wdata, vt[k].exp_rdata, vt[k].exp_err, k % 2);

    for (int k = 0; k < NW; k++) m_loc[k] = '0;
    for (int k = 0; k < NS; k++) m_sh[k] = '0;

    for (int t = 0; t < 200; t++) begin
      pick = int'($urandom_range(0, 99));
      op = (pick < 45) ? 2'd0 : (pick < 90) ? 2'd1 : (pick < 94) ? 2'd2 : 2'd3;
      sz = 1'($urandom_range(0, 1));
      sh = ($urandom_range(0, 4) == 0);
      if (sh)      idx = 8'($urandom_range(0, 5));
      else if (sz) idx = 8'($urandom_range(0, 9));
      else         idx = 8'($urandom_range(0, 17));
      run_model($sformatf("rnd%0d", t), op, sz, sh, idx, {$urandom, $urandom},
                int'($urandom_range(0, 2)));
    end

    run_model("bp_write", 2'd1, 0, 0, 8'd3, 64'h1234, 0);
    run_model("bp_read", 2'd0, 0, 0, 8'd3, 64'd0, 3);

    run_model("pre_rst_dw", 2'd1, 1, 0, 8'd2, 64'hAAAA5555_12345678, 0);
    run_model("pre_rst_w", 2'd1, 0, 0, 8'd9, 64'h99, 0);
    req_valid = 1'b1; req_op = 2'd1; req_size = 1'b1; req_shared = 1'b0;
    req_index = 8'd1; req_wdata = 64'hCAFEF00D_BEEF0001;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    check("mid_rst_outputs", {60'd0, req_ready, rsp_valid, rsp_err, |rsp_rdata}, 64'b1000);
    rst_n = 1'b1;
    for (int k = 0; k < NW; k++) m_loc[k] = '0;
    for (int k = 0; k < NS; k++) m_sh[k] = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_rst_no_rsp", {62'd0, rsp_valid, req_ready}, 64'b01);
    end
    for (int k = 0; k < NW; k++)
      run_model($sformatf("post_rst_w%0d", k), 2'd0, 0, 0, 8'(k), 64'd0, 0);
    for (int k = 0; k < NS; k++)
      run_model($sformatf("post_rst_s%0d", k), 2'd0, 0, 1, 8'(k), 64'd0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
